// File: rtl/master_port.sv
`timescale 1ns/1ps
// Serial bus master: accepts one user request and sends start, address and
// write data LSB first. It then waits for the slave ACK and, for reads, shifts in 8 data bits.
module master_port #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        M_REQ,
  input  logic        M_RW,
  input  logic [11:0] M_ADDR,
  input  logic [7:0]  M_DIN,
  output logic        M_BUSY,
  output logic        M_DONE,
  output logic [7:0]  M_DOUT,
  output logic        M_ERR,
  output logic        B_VALID,
  output logic        B_RW,
  output logic        B_BUS_OUT,
  input  logic        B_BUS_IN,
  input  logic        B_ACK,
  input  logic        B_SBSY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state;
  logic        rw_q;
  logic [11:0] addr_q;
  logic [7:0]  din_q;
  logic [3:0]  bit_cnt;
  logic [7:0]  to_cnt;
  logic [7:0]  rx_q;
  logic        err_q;
  logic        ack_ok;
  logic [7:0]  rx_next;

  assign ack_ok  = B_ACK & ~B_SBSY;
  assign rx_next = {B_BUS_IN, rx_q[7:1]};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= S_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      M_DOUT  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (M_REQ && !B_SBSY) begin
            rw_q   <= M_RW;
            addr_q <= M_ADDR;
            din_q  <= M_DIN;
            err_q  <= 1'b0;
            state  <= S_START;
          end
        end
        S_START: begin
          bit_cnt <= '0;
          state   <= S_ADDR;
        end
        S_ADDR: begin
          if (bit_cnt == 4'd11) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            state   <= rw_q ? S_WDATA : S_WAIT;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_WDATA: begin
          if (bit_cnt == 4'd7) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            state   <= S_WAIT;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        // An acknowledge seen on the same edge as the final timeout count still succeeds.
        S_WAIT: begin
          if (ack_ok) begin
            bit_cnt <= '0;
            state   <= rw_q ? S_DONE : S_RDATA;
          end else if (to_cnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_RDATA: begin
          rx_q <= rx_next;
          if (bit_cnt == 4'd7) begin
            M_DOUT <= rx_next;
            state  <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    M_BUSY    = (state != S_IDLE);
    M_DONE    = (state == S_DONE);
    M_ERR     = (state == S_DONE) & err_q;
    B_VALID   = (state == S_START) || (state == S_ADDR) || (state == S_WDATA) ||
                (state == S_WAIT) || (state == S_RDATA);
    B_RW      = B_VALID ? rw_q : 1'b1;
    B_BUS_OUT = 1'b0;
    case (state)
      S_START: B_BUS_OUT = 1'b1;
      S_ADDR:  B_BUS_OUT = addr_q[bit_cnt];
      S_WDATA: B_BUS_OUT = din_q[bit_cnt[2:0]];
      default: B_BUS_OUT = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_master_port.sv
`timescale 1ns/1ps
// Self-checking bench for master_port: reset/abort sequences, a vector table
// of frames, and randomized frames against a transaction-level model.
module tb_master_port;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        M_REQ;
  logic        M_RW;
  logic [11:0] M_ADDR;
  logic [7:0]  M_DIN;
  logic        M_BUSY;
  logic        M_DONE;
  logic [7:0]  M_DOUT;
  logic        M_ERR;
  logic        B_VALID;
  logic        B_RW;
  logic        B_BUS_OUT;
  logic        B_BUS_IN;
  logic        B_ACK;
  logic        B_SBSY;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [20:0] seen;
  logic [7:0]  model_dout;

  typedef struct {
    logic        rw;
    logic [11:0] addr;
    logic [7:0]  din;
    int          ack_delay;
    logic [7:0]  rdata;
    logic        exp_err;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[7];

  master_port #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR),
    .M_DIN(M_DIN), .M_BUSY(M_BUSY), .M_DONE(M_DONE), .M_DOUT(M_DOUT),
    .M_ERR(M_ERR), .B_VALID(B_VALID), .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT),
    .B_BUS_IN(B_BUS_IN), .B_ACK(B_ACK), .B_SBSY(B_SBSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name);
    check_output(name, {27'd0, M_BUSY, B_VALID, B_RW, B_BUS_OUT, M_DONE, M_ERR} & 32'h3F,
                 32'b001000);
  endtask

  // Drives one complete transaction from IDLE and checks every cycle of it.
  // ack_delay = number of WAIT_ACK edges that see no usable ACK before one does.
  task automatic apply_frame(input logic rw, input logic [11:0] addr, input logic [7:0] din,
                             input int ack_delay, input logic [7:0] rdata,
                             input logic exp_err, input logic [7:0] exp_dout);
    logic stream[$];
    int   wait_edges;
    logic success;
    stream.push_back(1'b1);
    for (int i = 0; i < 12; i++) stream.push_back(addr[i]);
    if (rw) for (int i = 0; i < 8; i++) stream.push_back(din[i]);
    success    = (ack_delay < TO);
    wait_edges = success ? ack_delay + 1 : TO;
    seen = '0;
    M_REQ = 1'b1; M_RW = rw; M_ADDR = addr; M_DIN = din; B_SBSY = 1'b0; B_ACK = 1'b0;
    tick();
    M_REQ = 1'($urandom); M_RW = ~rw; M_ADDR = 12'($urandom); M_DIN = 8'($urandom);
    foreach (stream[i]) begin
      check_output("frame_bits", {27'd0, B_VALID, B_RW, M_BUSY, M_DONE, B_BUS_OUT},
                   {27'd0, 1'b1, rw, 1'b1, 1'b0, stream[i]});
      seen = {seen[19:0], B_BUS_OUT};
      tick();
    end
    for (int k = 1; k <= wait_edges; k++) begin
      check_output("wait_ack", {27'd0, B_VALID, B_RW, M_BUSY, M_DONE, B_BUS_OUT},
                   {27'd0, 1'b1, rw, 1'b1, 1'b0, 1'b0});
      if (k == ack_delay + 1) begin
        B_ACK = 1'b1; B_SBSY = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        B_ACK = 1'b0; B_SBSY = 1'($urandom);
      end else begin
        B_ACK = 1'b1; B_SBSY = 1'b1;
      end
      tick();
    end
    B_ACK = 1'b0; B_SBSY = 1'b0;
    if (success && !rw) begin
      for (int i = 0; i < 8; i++) begin
        check_output("rdata_frame", {29'd0, B_VALID, B_RW, M_DONE}, {29'd0, 1'b1, 1'b0, 1'b0});
        B_BUS_IN = rdata[i];
        tick();
      end
    end
    M_REQ = 1'b0;
    check_output("done_pulse", {28'd0, B_VALID, M_BUSY, M_DONE, M_ERR},
                 {28'd0, 1'b0, 1'b1, 1'b1, exp_err});
    check_output("done_dout", {24'd0, M_DOUT}, {24'd0, exp_dout});
    tick();
    check_idle("after_done");
    check_output("dout_hold", {24'd0, M_DOUT}, {24'd0, exp_dout});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 12'h0A5, 8'h3C, 0,  8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 12'h7FF, 8'h00, 0,  8'hA5, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 12'h123, 8'h00, 16, 8'hFF, 1'b1, 8'hA5};
    vecs[3] = '{1'b0, 12'h456, 8'h00, 15, 8'h5A, 1'b0, 8'h5A};
    vecs[4] = '{1'b1, 12'hFFF, 8'h81, 15, 8'h00, 1'b0, 8'h5A};
    vecs[5] = '{1'b1, 12'h800, 8'h7E, 30, 8'h00, 1'b1, 8'h5A};
    vecs[6] = '{1'b0, 12'h000, 8'h00, 3,  8'h00, 1'b0, 8'h00};

    RSTN = 1'b0; M_REQ = 1'b0; M_RW = 1'b0; M_ADDR = '0; M_DIN = '0;
    B_BUS_IN = 1'b0; B_ACK = 1'b0; B_SBSY = 1'b0;
    tick(); tick();
    check_idle("reset_state");
    check_output("reset_dout", {24'd0, M_DOUT}, 32'h0);
    RSTN = 1'b1;
    tick();
    check_idle("idle_after_reset");

    // Slave busy holds off the request; START follows the edge after busy drops.
    M_REQ = 1'b1; M_RW = 1'b1; M_ADDR = 12'h0C5; M_DIN = 8'h11; B_SBSY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("sbsy_hold", {30'd0, M_BUSY, B_VALID}, 32'h0);
    end
    B_SBSY = 1'b0;
    tick();
    check_output("start_after_sbsy", {29'd0, B_VALID, B_BUS_OUT, M_BUSY}, 32'b111);
    M_REQ = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_output("addr_bit6", {31'd0, B_BUS_OUT}, 32'h1);

    // Asynchronous reset in the middle of the address phase.
    #2 RSTN = 1'b0;
    #1;
    check_idle("async_reset");
    check_output("async_reset_dout", {24'd0, M_DOUT}, 32'h0);
    tick();
    check_output("no_done_in_reset", {31'd0, M_DONE}, 32'h0);
    RSTN = 1'b1;
    tick();
    check_idle("idle_after_abort");

    for (int v = 0; v < 7; v++) begin
      apply_frame(vecs[v].rw, vecs[v].addr, vecs[v].din, vecs[v].ack_delay,
                  vecs[v].rdata, vecs[v].exp_err, vecs[v].exp_dout);
      if (v == 0) check_output("write_stream_0A5_3C", {11'd0, seen}, {11'd0, 21'b110100101000000111100});
    end
    model_dout = vecs[6].exp_dout;

    for (int n = 0; n < 40; n++) begin
      logic       rw;
      logic [11:0] addr;
      logic [7:0] din;
      logic [7:0] rdata;
      int         dly;
      logic       err;
      rw    = 1'($urandom);
      addr  = 12'($urandom);
      din   = 8'($urandom);
      rdata = 8'($urandom);
      dly   = $urandom_range(0, 20);
      err   = (dly >= TO);
      if (!rw && !err) model_dout = rdata;
      apply_frame(rw, addr, din, dly, rdata, err, model_dout);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
